muldiv_unit: RTL and testbench

Parametrised multi-cycle RV32M multiply/divide execution unit. It sits in the EX stage beside the single-cycle ALU path and receives operands that have already been forwarded. It stalls the pipeline while an operation is in flight and returns a one-cycle result pulse tagged with the destination register. Multiply uses a fixed-latency register pipeline; divide is an iterative radix-2 restoring engine with early exit for special cases.

---
 rtl/muldiv_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide execution unit.
// Multiply holds captured operands for MUL_STAGES cycles before writeback.
// Divide is a radix-2 restoring engine on operand magnitudes with a final
// sign-correction edge. Divide-by-zero and signed overflow take a one-cycle
// early exit instead of iterating.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            ready,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_e;

  localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_0   = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_1   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   MUL_END = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0]   DIV_END = CW'(XLEN);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic              special_q, special_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        result_rd_q, result_rd_d;
  logic              result_valid_q, result_valid_d;

  logic [2*XLEN-1:0] mul_a_ext_s, mul_b_ext_s, mul_prod_s;
  logic [XLEN-1:0]   mul_res_s;
  logic              div_signed_s, q_neg_s, r_neg_s, fits_s;
  logic [XLEN-1:0]   div_b_abs_s, q_fix_s, r_fix_s, div_res_s;
  logic [XLEN:0]     rem_shift_s, trial_s;
  logic              in_signed_s, div_zero_s, div_ovf_s;
  logic [XLEN-1:0]   in_a_abs_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      a_q            <= ZERO;
      b_q            <= ZERO;
      op_q           <= 2'b00;
      rd_q           <= 5'd0;
      cnt_q          <= CNT_0;
      rem_q          <= ZERO;
      quo_q          <= ZERO;
      special_q      <= 1'b0;
      result_q       <= ZERO;
      result_rd_q    <= 5'd0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      special_q      <= special_d;
      result_q       <= result_d;
      result_rd_q    <= result_rd_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Multiply product from captured operands, extended per funct3 signedness.
  always_comb begin
    mul_a_ext_s = {{XLEN{(op_q != 2'b11) & a_q[XLEN-1]}}, a_q};
    mul_b_ext_s = {{XLEN{~op_q[1] & b_q[XLEN-1]}}, b_q};
    mul_prod_s  = mul_a_ext_s * mul_b_ext_s;
    mul_res_s   = (op_q == 2'b00) ? mul_prod_s[XLEN-1:0] : mul_prod_s[2*XLEN-1:XLEN];
  end

  // Divide step, sign correction and special-case detection at accept.
  always_comb begin
    div_signed_s = ~op_q[0];
    div_b_abs_s  = (div_signed_s & b_q[XLEN-1]) ? -b_q : b_q;
    rem_shift_s  = {rem_q, quo_q[XLEN-1]};
    trial_s      = rem_shift_s - {1'b0, div_b_abs_s};
    fits_s       = ~trial_s[XLEN];
    q_neg_s      = div_signed_s & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg_s      = div_signed_s & a_q[XLEN-1];
    q_fix_s      = q_neg_s ? -quo_q : quo_q;
    r_fix_s      = r_neg_s ? -rem_q : rem_q;
    if (special_q) begin
      div_res_s = op_q[1] ? rem_q : quo_q;
    end else begin
      div_res_s = op_q[1] ? r_fix_s : q_fix_s;
    end
    in_signed_s = ~funct3[0];
    in_a_abs_s  = (in_signed_s & rs1[XLEN-1]) ? -rs1 : rs1;
    div_zero_s  = (rs2 == ZERO);
    div_ovf_s   = in_signed_s & (rs1 == MIN_NEG) & (rs2 == ONES);
  end

  // Next-state logic; flush returns to idle from any state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = funct3[2] ? ST_DIV : ST_MUL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_q == MUL_END) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_MUL;
          end
        end
        ST_DIV: begin
          if (special_q || (cnt_q == DIV_END)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DIV;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath updates: operand capture, iteration and result writeback.
  always_comb begin
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    rd_d           = rd_q;
    cnt_d          = cnt_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    special_d      = special_q;
    result_d       = result_q;
    result_rd_d    = result_rd_q;
    result_valid_d = 1'b0;
    if (flush) begin
      special_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_d   = rs1;
            b_d   = rs2;
            op_d  = funct3[1:0];
            rd_d  = rd_addr;
            cnt_d = CNT_0;
            if (funct3[2] && (div_zero_s || div_ovf_s)) begin
              special_d = 1'b1;
              quo_d     = div_zero_s ? ONES : rs1;
              rem_d     = div_zero_s ? rs1 : ZERO;
            end else begin
              special_d = 1'b0;
              quo_d     = in_a_abs_s;
              rem_d     = ZERO;
            end
          end else begin
            special_d = special_q;
          end
        end
        ST_MUL: begin
          if (cnt_q == MUL_END) begin
            result_d       = mul_res_s;
            result_rd_d    = rd_q;
            result_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_1;
          end
        end
        ST_DIV: begin
          if (special_q || (cnt_q == DIV_END)) begin
            result_d       = div_res_s;
            result_rd_d    = rd_q;
            result_valid_d = 1'b1;
            special_d      = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_1;
            rem_d = fits_s ? trial_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], fits_s};
          end
        end
        default: begin
          special_d = 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs and registered result drive.
  always_comb begin
    ready        = (state_q == ST_IDLE);
    stall        = (state_q != ST_IDLE) | (start & (state_q == ST_IDLE));
    result_valid = result_valid_q;
    result       = result_q;
    result_rd    = result_rd_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: cycle-level behavioural model plus directed ops.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        ready;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  result_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: edges left until writeback, pending and visible results
  int          m_rem;
  logic        m_valid;
  logic [31:0] m_res, m_pres;
  logic [4:0]  m_rd, m_prd;

  muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .rd_addr(rd_addr), .flush(flush), .ready(ready), .stall(stall),
    .result_valid(result_valid), .result(result), .result_rd(result_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M reference semantics in plain arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, q;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 32'h0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      5: return 32'h0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // compare process: checks every cycle at negedge, then advances the model
  initial begin
    logic e_ready;
    m_rem = 0; m_valid = 1'b0; m_res = 32'h0; m_rd = 5'd0; m_pres = 32'h0; m_prd = 5'd0;
    forever begin
      @(negedge clk);
      e_ready = (m_rem == 0);
      check("ready", ready, e_ready);
      check("stall", stall, (m_rem != 0) || (start && e_ready));
      check("result_valid", result_valid, m_valid);
      check("result", result, m_res);
      check("result_rd", result_rd, m_rd);
      if (rst) begin
        m_rem = 0; m_valid = 1'b0; m_res = 32'h0; m_rd = 5'd0;
      end else if (flush) begin
        m_rem = 0; m_valid = 1'b0;
      end else if (m_rem == 0) begin
        m_valid = 1'b0;
        if (start) begin
          m_rem  = latency(funct3, rs1, rs2);
          m_pres = ref_result(funct3, rs1, rs2);
          m_prd  = rd_addr;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_valid = 1'b1; m_res = m_pres; m_rd = m_prd;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one op, wait (bounded) for its pulse, check latency and value
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
    int n;
    bit got;
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_addr = rd;
    tick();
    start = 1'b0; funct3 = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = $urandom;
    rd_addr = 5'($urandom_range(0, 31));
    n = 0; got = 1'b0;
    while (n < 100 && !got) begin
      tick();
      n++;
      if (result_valid) got = 1'b1;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("op_result", result, exp_res);
    check("op_rd", result_rd, rd);
  endtask

  initial begin
    int cnt;
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
    rs1 = 32'h0; rs2 = 32'h0; rd_addr = 5'd0;
    tick(); tick();
    rst = 1'b0;
    check("reset_valid", result_valid, 1'b0);
    check("reset_result", result, 32'h0);
    check("reset_ready", ready, 1'b1);

    // multiply, including upper halves
    run_op(3'd0, 32'd7, 32'hFFFF_FFF9, 5'd5, 32'hFFFF_FFCF, 2);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 2);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 2);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 2);
    // iterative divide
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h7FFF_FFFC, 33);
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'h0000_0001, 33);
    // special cases
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1);
    run_op(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, 1);
    run_op(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);

    // flush mid-divide: no pulse, result held
    tick();
    start = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd_addr = 5'd20;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", ready, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) cnt++;
      tick();
    end
    check("flush_no_pulse", 64'(cnt), 64'd0);
    check("flush_result_held", result, 32'hFFFF_FFFF);
    check("flush_rd_held", result_rd, 5'd13);

    // start while busy is ignored
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7; rd_addr = 5'd9;
    tick();
    funct3 = 3'd4; rs1 = 32'd100; rs2 = 32'd3; rd_addr = 5'd17;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) cnt++;
      tick();
    end
    check("busy_start_pulses", 64'(cnt), 64'd1);
    check("busy_start_result", result, 32'd42);
    check("busy_start_rd", result_rd, 5'd9);

    // flush together with start in idle
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_addr = 5'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_ready", ready, 1'b1);
    repeat (4) tick();
    check("flush_start_result", result, 32'd42);

    // reset mid-divide, then a normal multiply
    start = 1'b1; funct3 = 3'd5; rs1 = 32'd999; rs2 = 32'd4; rd_addr = 5'd22;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", result_valid, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_rd", result_rd, 5'd0);
    check("rst_ready", ready, 1'b1);
    run_op(3'd0, 32'd3, 32'd4, 5'd14, 32'd12, 2);

    // randomized ops, mostly back-to-back
    for (int k = 0; k < 150; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 15) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      repeat ($urandom_range(0, 2)) tick();
      run_op(f3, a, b, 5'($urandom_range(0, 31)), ref_result(f3, a, b), latency(f3, a, b));
    end

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
